psc_trigger_receiver: RTL

//  Receive end of the PSC trigger link. Deserialises the 10 Mb/s serial line that the trigger transmitter drives.

---
 rtl/psc_trigger_receiver.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/psc_trigger_receiver.sv
// -----------------------------------------------------------------------------
// psc_trigger_receiver
//   Receive end of the PSC trigger link. Deserialises 10-bit UART-style words
//   (start 0, data[7:0] MSB first, stop 1) from the asynchronous serial line and
//   assembles them into packets of SYNC, CMD, payload and CRC-8 (poly 0x07).
//   A CRC-good packet produces a one-clock pkt_valid pulse. If its CMD equals
//   TRIG_CMD, trigger_out pulses on the same clock.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high
//   psc_input    in   1  asynchronous serial line (idles high)
//   rx_data      out  8  last received byte
//   rx_valid     out  1  1-clk pulse: rx_data updated
//   cmd_out      out  8  CMD byte of last CRC-good packet
//   pkt_valid    out  1  1-clk pulse: CRC-good packet completed
//   trigger_out  out  1  1-clk pulse: CRC-good packet with CMD == TRIG_CMD
//   crc_error    out  1  1-clk pulse: CRC mismatch on the final byte
//   frame_error  out  1  1-clk pulse: bad stop bit, or inter-byte timeout
// -----------------------------------------------------------------------------
module psc_trigger_receiver #(
  parameter int unsigned CLKS_PER_BIT = 5,
  parameter int unsigned PKT_LEN      = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [7:0]  TRIG_CMD     = 8'h01,
  parameter int unsigned TIMEOUT_CLKS = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psc_input,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [7:0] cmd_out,
  output logic       pkt_valid,
  output logic       trigger_out,
  output logic       crc_error,
  output logic       frame_error
);

  localparam int unsigned BCNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = $clog2(PKT_LEN);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [BCNT_W-1:0] BCNT_MID  = BCNT_W'(CLKS_PER_BIT / 2);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_CMD   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PKT_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    BIT_IDLE  = 2'd0,
    BIT_START = 2'd1,
    BIT_DATA  = 2'd2,
    BIT_STOP  = 2'd3
  } bit_state_e;

  typedef enum logic {
    PKT_HUNT = 1'b0,
    PKT_BODY = 1'b1
  } pkt_state_e;

  // CRC-8, poly 0x07, MSB first; bytewise form equals bit-serial MSB-first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                             input logic [7:0] data_in);
    logic [7:0] c;
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Line synchroniser; sync3_q is the previous synced sample for edge detect.
  // Reset to 1 so leaving reset never looks like a falling edge.
  logic sync1_q, sync2_q, sync3_q;
  logic fall_s;

  bit_state_e        bit_state_q, bit_state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              stop_err_s;

  pkt_state_e        pkt_state_q, pkt_state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        crc_q, crc_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        cmd_out_q, cmd_out_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              trigger_q, trigger_d;
  logic              crc_error_q, crc_error_d;
  logic              frame_error_q, frame_error_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  assign fall_s = sync3_q & ~sync2_q;

  // Bit FSM next state: start-bit qualification, mid-bit sampling, stop check.
  always_comb begin
    bit_state_d = bit_state_q;
    bcnt_d      = bcnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    stop_err_s  = 1'b0;
    case (bit_state_q)
      BIT_IDLE: begin
        bcnt_d = '0;
        if (fall_s) begin
          bit_state_d = BIT_START;
        end else begin
          bit_state_d = BIT_IDLE;
        end
      end
      BIT_START: begin
        if (bcnt_q == BCNT_MID) begin
          bcnt_d = '0;
          if (!sync2_q) begin
            bit_state_d = BIT_DATA;
            bit_idx_d   = 3'd7;
          end else begin
            // Line back high at mid start bit: glitch, silently dropped.
            bit_state_d = BIT_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      BIT_DATA: begin
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d  = '0;
          shift_d = {shift_q[6:0], sync2_q};
          if (bit_idx_q == 3'd0) begin
            bit_state_d = BIT_STOP;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      BIT_STOP: begin
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d      = '0;
          bit_state_d = BIT_IDLE;
          if (sync2_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            // Low stop bit: the line is already low, so IDLE waits for the
            // next genuine 1->0 edge rather than taking this as a start bit.
            stop_err_s = 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: begin
        bit_state_d = BIT_IDLE;
        bcnt_d      = '0;
      end
    endcase
  end

  // Packet FSM next state: fed by rx_valid_q, so packet pulses trail it by 1 clk.
  always_comb begin
    pkt_state_d   = pkt_state_q;
    idx_d         = idx_q;
    crc_d         = crc_q;
    cmd_d         = cmd_q;
    cmd_out_d     = cmd_out_q;
    pkt_valid_d   = 1'b0;
    trigger_d     = 1'b0;
    crc_error_d   = 1'b0;
    frame_error_d = 1'b0;
    tmo_cnt_d     = tmo_cnt_q;
    case (pkt_state_q)
      PKT_HUNT: begin
        tmo_cnt_d = '0;
        if (rx_valid_q && (rx_data_q == SYNC_BYTE)) begin
          pkt_state_d = PKT_BODY;
          idx_d       = IDX_CMD;
          crc_d       = crc8_update(8'h00, SYNC_BYTE);
        end else begin
          pkt_state_d = PKT_HUNT;
        end
      end
      PKT_BODY: begin
        // A completing byte takes priority over a timeout on the same clock.
        if (rx_valid_q) begin
          tmo_cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            if (rx_data_q == crc_q) begin
              pkt_valid_d = 1'b1;
              cmd_out_d   = cmd_q;
              trigger_d   = (cmd_q == TRIG_CMD);
            end else begin
              crc_error_d = 1'b1;
            end
            pkt_state_d = PKT_HUNT;
            idx_d       = '0;
            crc_d       = 8'h00;
          end else begin
            crc_d = crc8_update(crc_q, rx_data_q);
            if (idx_q == IDX_CMD) begin
              cmd_d = rx_data_q;
            end else begin
              cmd_d = cmd_q;
            end
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          frame_error_d = 1'b1;
          pkt_state_d   = PKT_HUNT;
          idx_d         = '0;
          crc_d         = 8'h00;
          tmo_cnt_d     = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: begin
        pkt_state_d = PKT_HUNT;
        idx_d       = '0;
        crc_d       = 8'h00;
        tmo_cnt_d   = '0;
      end
    endcase
    // A bad stop bit aborts whatever packet was in progress.
    if (stop_err_s) begin
      frame_error_d = 1'b1;
      pkt_state_d   = PKT_HUNT;
      idx_d         = '0;
      crc_d         = 8'h00;
      tmo_cnt_d     = '0;
    end else begin
      frame_error_d = frame_error_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      sync3_q       <= 1'b1;
      bit_state_q   <= BIT_IDLE;
      bcnt_q        <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      pkt_state_q   <= PKT_HUNT;
      idx_q         <= '0;
      crc_q         <= 8'h00;
      cmd_q         <= 8'h00;
      cmd_out_q     <= 8'h00;
      pkt_valid_q   <= 1'b0;
      trigger_q     <= 1'b0;
      crc_error_q   <= 1'b0;
      frame_error_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      sync1_q       <= psc_input;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      bit_state_q   <= bit_state_d;
      bcnt_q        <= bcnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      pkt_state_q   <= pkt_state_d;
      idx_q         <= idx_d;
      crc_q         <= crc_d;
      cmd_q         <= cmd_d;
      cmd_out_q     <= cmd_out_d;
      pkt_valid_q   <= pkt_valid_d;
      trigger_q     <= trigger_d;
      crc_error_q   <= crc_error_d;
      frame_error_q <= frame_error_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign cmd_out     = cmd_out_q;
  assign pkt_valid   = pkt_valid_q;
  assign trigger_out = trigger_q;
  assign crc_error   = crc_error_q;
  assign frame_error = frame_error_q;

endmodule
